instr_loader: RTL and testbench

- Inverse of the instruction decode path: accepts instruction fields (opcode, rd, rs1, rs2, imm, jump target) and packs them into the 16-bit instruction word.
- Streams each word into the 8-bit program memory as two byte writes, high byte first, so the fetch unit reassembles it.
- Used by the boot/test loader to place programs into program memory before the CPU runs.

---
 rtl/instr_loader_pkg.sv | 46 ++++
 rtl/instr_packer.sv | 34 +++
 rtl/instr_loader.sv | 155 +++++++++++++++
 tb/tb_instr_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared instruction-set definitions: opcodes, formats and field positions.
// LOADER_HALT_STOP_EN adds a STOPPED state entered after an HLT word is written.
package instr_loader_pkg;

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_SLL  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hD;
  localparam logic [3:0] OP_NAND = 4'hE;
  localparam logic [3:0] OP_BLT  = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;
  localparam int JT_LSB  = 0;

  typedef enum logic [1:0] {R_TYPE, I_TYPE, J_TYPE, NONE} instr_fmt_e;

`ifdef LOADER_HALT_STOP_EN
  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, STOPPED} ld_state_e;
`else
  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO} ld_state_e;
`endif

  function automatic instr_fmt_e op_format(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLT: return R_TYPE;
      OP_JMP:                 return J_TYPE;
      OP_HLT:                 return NONE;
      default:                return I_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational packing of instruction fields into a 16-bit word.
// Fields unused by the opcode's format are forced to zero.
module instr_packer
  import instr_loader_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [5:0]  imm,
  input  logic [11:0] jtarget,
  output logic [15:0] word
);

  always_comb begin
    word = '0;
    word[OPC_LSB +: 4] = opcode;
    case (op_format(opcode))
      R_TYPE: begin
        word[RD_LSB  +: 3] = rd;
        word[RS1_LSB +: 3] = rs1;
        word[RS2_LSB +: 3] = rs2;
      end
      I_TYPE: begin
        word[RD_LSB  +: 3] = rd;
        word[RS1_LSB +: 3] = rs1;
        word[IMM_LSB +: 6] = imm;
      end
      J_TYPE:  word[JT_LSB +: 12] = jtarget;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Packs instruction fields and streams each word into byte-wide program memory,
// high byte first. LOADER_HALT_STOP_EN: stop accepting after an HLT word.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [2:0]            rd,
  input  logic [2:0]            rs1,
  input  logic [2:0]            rs2,
  input  logic [5:0]            imm,
  input  logic [11:0]           jtarget,
  input  logic                  load_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] instr_count
);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, cnt_q, cnt_d, mem_addr_q, mem_addr_d;
  logic [15:0]           word_q, word_d, packed_word;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d, full_q, full_d;
  logic [ADDR_WIDTH-1:0] ptr_next, load_ptr;
  logic                  last_slot, halt_word, accept;

  instr_packer u_packer (
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .jtarget (jtarget),
    .word    (packed_word)
  );

  assign ptr_next  = ptr_q + ADDR_WIDTH'(2);
  assign last_slot = (ptr_next == '0);
  assign load_ptr  = {start_addr[ADDR_WIDTH-1:1], 1'b0};
`ifdef LOADER_HALT_STOP_EN
  assign halt_word = (word_q[OPC_LSB +: 4] == OP_HLT);
`else
  assign halt_word = 1'b0;
`endif

  // A follow-on accept during the write that fills the last slot would wrap
  // onto address 0, so it is refused just like an accept while full.
  always_comb begin
    in_ready = 1'b0;
    if (!full_q && !load_addr)
      in_ready = (state_q == IDLE) ||
                 ((state_q == WR_LO) && !last_slot && !halt_word);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    full_d      = full_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (load_addr) begin
          ptr_d  = load_ptr;
          cnt_d  = '0;
          full_d = 1'b0;
        end else if (accept) begin
          word_d      = packed_word;
          state_d     = WR_HI;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = packed_word[15:8];
        end
      end
      WR_HI: begin
        state_d     = WR_LO;
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q + ADDR_WIDTH'(1);
        mem_wdata_d = word_q[7:0];
      end
      WR_LO: begin
        ptr_d  = ptr_next;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        full_d = last_slot;
        if (accept) begin
          word_d      = packed_word;
          state_d     = WR_HI;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_next;
          mem_wdata_d = packed_word[15:8];
        end else begin
`ifdef LOADER_HALT_STOP_EN
          state_d = halt_word ? STOPPED : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef LOADER_HALT_STOP_EN
      STOPPED: begin
        if (load_addr) begin
          ptr_d   = load_ptr;
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= RESET_ADDR;
      cnt_q       <= '0;
      word_q      <= '0;
      full_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      full_q      <= full_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign full        = full_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus a randomized
// stream compared against a field-packing reference and a write log.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [2:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [5:0]  imm = '0;
  logic [11:0] jtarget = '0;
  logic        load_addr = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata;
  logic        full;
  logic [7:0]  instr_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];

  instr_loader #(.ADDR_WIDTH(8), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .jtarget(jtarget),
    .load_addr(load_addr), .start_addr(start_addr), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference packing written straight from the format table.
  function automatic logic [15:0] pack_ref(input logic [3:0] op, input logic [2:0] d,
      input logic [2:0] s1, input logic [2:0] s2, input logic [5:0] im, input logic [11:0] jt);
    if (op == 4'd1 || op == 4'd4 || op == 4'd7) return {op, d, s1, s2, 3'b000};
    if (op == 4'd9)  return {op, jt};
    if (op == 4'd13) return {op, 12'h000};
    return {op, d, s1, im};
  endfunction

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic expect_word(input logic [7:0] a, input logic [15:0] w);
    exp_addr.push_back(a);     exp_data.push_back(w[15:8]);
    exp_addr.push_back(a + 8'd1); exp_data.push_back(w[7:0]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; load_addr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] a);
    load_addr = 1'b1; start_addr = a;
    @(negedge clk);
    load_addr = 1'b0;
  endtask

  // Offers one instruction; returns the cycle index in which it was accepted.
  task automatic send(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
      input logic [2:0] s2, input logic [5:0] im, input logic [11:0] jt, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; jtarget = jt;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout op=%0h in_ready=%b required=1", op, in_ready);
      in_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, full, instr_count, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs we=%b addr=%h data=%h full=%b cnt=%0d rdy=%b required 0/00/00/0/0/1",
               mem_we, mem_addr, mem_wdata, full, instr_count, in_ready);
    end
  endtask

  task automatic test_addi();
    int a;
    clear_log();
    send(4'd0, 3'd1, 3'd2, 3'($urandom), 6'd5, 12'($urandom), a);
    idle(4); #1;
    total++;
    if (log_addr.size() !== 2) begin
      bad++; $display("FAIL addi_nwrites got=%0d required=2", log_addr.size());
    end else begin
      total++;
      if ({log_addr[0], log_data[0], log_cyc[0]} !== {8'h00, 8'h02, a + 1}) begin
        bad++; $display("FAIL addi_hi got=%h@%h c%0d required=02@00 c%0d", log_data[0], log_addr[0], log_cyc[0], a + 1);
      end
      total++;
      if ({log_addr[1], log_data[1], log_cyc[1]} !== {8'h01, 8'h85, a + 2}) begin
        bad++; $display("FAIL addi_lo got=%h@%h c%0d required=85@01 c%0d", log_data[1], log_addr[1], log_cyc[1], a + 2);
      end
    end
    total++;
    if (instr_count !== 8'd1) begin
      bad++; $display("FAIL addi_count got=%0d required=1", instr_count);
    end
  endtask

  task automatic test_add_junk();
    int a;
    clear_log();
    send(4'd1, 3'd3, 3'd1, 3'd2, 6'h3F, 12'hFFF, a);
    idle(4); #1;
    expect_word(8'h02, 16'h1650);
    total++;
    if (log_addr.size() !== 2) begin
      bad++; $display("FAIL add_nwrites got=%0d required=2", log_addr.size());
    end else
      for (int i = 0; i < 2; i++) begin
        total++;
        if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          bad++; $display("FAIL add_byte%0d got=%h@%h required=%h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    total++;
    if (instr_count !== 8'd2) begin
      bad++; $display("FAIL add_count got=%0d required=2", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    logic [7:0] bytes [4];
    bytes[0] = 8'h9A; bytes[1] = 8'hBC; bytes[2] = 8'hD0; bytes[3] = 8'h00;
    do_reset();
    clear_log();
    send(4'd9, 3'($urandom), 3'($urandom), 3'($urandom), 6'($urandom), 12'hABC, a0);
    send(4'd13, 3'd7, 3'd7, 3'($urandom), 6'h3F, 12'($urandom), a1);
    idle(4); #1;
    total++;
    if (log_addr.size() !== 4) begin
      bad++; $display("FAIL b2b_nwrites got=%0d required=4", log_addr.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({log_addr[i], log_data[i], log_cyc[i]} !== {8'(i), bytes[i], a0 + 1 + i}) begin
          bad++; $display("FAIL b2b_byte%0d got=%h@%h c%0d required=%h@%h c%0d",
                          i, log_data[i], log_addr[i], log_cyc[i], bytes[i], 8'(i), a0 + 1 + i);
        end
      end
  endtask

  task automatic test_full();
    int a;
    logic [15:0] w0, w1;
    clear_log();
    load(8'hFC); #1;
    total++;
    if ({full, instr_count} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL full_load got full=%b cnt=%0d required 0/0", full, instr_count);
    end
    w0 = pack_ref(4'd0, 3'($urandom), 3'($urandom), 3'd0, 6'($urandom), 12'd0);
    w1 = pack_ref(4'd0, 3'($urandom), 3'($urandom), 3'd0, 6'($urandom), 12'd0);
    send(4'd0, w0[11:9], w0[8:6], 3'($urandom), w0[5:0], 12'($urandom), a);
    send(4'd0, w1[11:9], w1[8:6], 3'($urandom), w1[5:0], 12'($urandom), a);
    idle(3);
    expect_word(8'hFC, w0);
    expect_word(8'hFE, w1);
    in_valid = 1'b1; opcode = 4'd0;
    repeat (8) @(negedge clk);
    #1;
    total++;
    if ({full, instr_count, in_ready} !== {1'b1, 8'd2, 1'b0}) begin
      bad++; $display("FAIL full_state got full=%b cnt=%0d rdy=%b required 1/2/0", full, instr_count, in_ready);
    end
    total++;
    if (log_addr.size() !== 4) begin
      bad++; $display("FAIL full_nwrites got=%0d required=4", log_addr.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          bad++; $display("FAIL full_byte%0d got=%h@%h required=%h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    in_valid = 1'b0;
    load(8'h10); #1;
    total++;
    if ({full, instr_count, in_ready} !== {1'b0, 8'd0, 1'b1}) begin
      bad++; $display("FAIL full_reload got full=%b cnt=%0d rdy=%b required 0/0/1", full, instr_count, in_ready);
    end
  endtask

  task automatic test_load_rules();
    int a;
    logic [15:0] w;
    clear_log();
    in_valid = 1'b1; opcode = 4'd2; load_addr = 1'b1; start_addr = 8'h21;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL load_prio_ready got=%b required=0", in_ready);
    end
    @(negedge clk);
    load_addr = 1'b0;
    idle(2);
    w = pack_ref(4'd2, 3'd4, 3'd5, 3'd0, 6'h2A, 12'd0);
    send(4'd2, 3'd4, 3'd5, 3'd6, 6'h2A, 12'h123, a);
    in_valid = 1'b0;
    expect_word(8'h20, w);
    // load_addr during the high-byte write must be ignored
    load(8'h80);
    idle(3);
    w = pack_ref(4'd7, 3'd1, 3'd2, 3'd3, 6'd0, 12'd0);
    send(4'd7, 3'd1, 3'd2, 3'd3, 6'h11, 12'h456, a);
    idle(4); #1;
    expect_word(8'h22, w);
    total++;
    if (log_addr.size() !== 4) begin
      bad++; $display("FAIL load_nwrites got=%0d required=4", log_addr.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          bad++; $display("FAIL load_byte%0d got=%h@%h required=%h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    total++;
    if (instr_count !== 8'd2) begin
      bad++; $display("FAIL load_count got=%0d required=2", instr_count);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    clear_log();
    send(4'd9, 3'd0, 3'd0, 3'd0, 6'd0, 12'h5A5, a);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, full, instr_count, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid we=%b addr=%h data=%h full=%b cnt=%0d rdy=%b required 0/00/00/0/0/1",
               mem_we, mem_addr, mem_wdata, full, instr_count, in_ready);
    end
    idle(3); #1;
    total++;
    if (log_addr.size() !== 1) begin
      bad++; $display("FAIL rst_mid_nwrites got=%0d required=1", log_addr.size());
    end
  endtask

  task automatic test_random();
    int a, gap;
    logic [7:0] base, ptr;
    logic [3:0] op;
    logic [2:0] d, s1, s2;
    logic [5:0] im;
    logic [11:0] jt;
    clear_log();
    base = 8'($urandom_range(0, 64) * 2);
    load(base);
    ptr = base;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom); d = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      im = 6'($urandom); jt = 12'($urandom);
`ifdef LOADER_HALT_STOP_EN
      if (op == 4'd13) op = 4'd0;
`endif
      expect_word(ptr, pack_ref(op, d, s1, s2, im, jt));
      ptr = ptr + 8'd2;
      send(op, d, s1, s2, im, jt, a);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(4); #1;
    total++;
    if (log_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL rand_nwrites got=%0d required=%0d", log_addr.size(), exp_addr.size());
    end else
      for (int i = 0; i < exp_addr.size(); i++) begin
        total++;
        if ({log_addr[i], log_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          bad++; $display("FAIL rand_byte%0d got=%h@%h required=%h@%h", i, log_data[i], log_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    total++;
    if (instr_count !== 8'd24) begin
      bad++; $display("FAIL rand_count got=%0d required=24", instr_count);
    end
  endtask

`ifdef LOADER_HALT_STOP_EN
  task automatic test_halt_stop();
    int a;
    clear_log();
    load(8'h40);
    send(4'd13, 3'd1, 3'd1, 3'd1, 6'd1, 12'd1, a);
    in_valid = 1'b1; opcode = 4'd0;
    repeat (6) @(negedge clk);
    #1;
    total++;
    if ({in_ready, mem_we, log_addr.size() == 2} !== 3'b001) begin
      bad++; $display("FAIL halt_stop rdy=%b we=%b nwrites=%0d required 0/0/2", in_ready, mem_we, log_addr.size());
    end
    in_valid = 1'b0;
    load(8'h50); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL halt_reload_ready got=%b required=1", in_ready);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_addi();
    test_add_junk();
    test_back_to_back();
    test_full();
    test_load_rules();
    test_reset_mid();
    test_random();
`ifdef LOADER_HALT_STOP_EN
    test_halt_stop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
